if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions in a small FIFO and presents one instruction per cycle, with its PC and pre-extracted rs1/rs2/rd/opcode fields, to the IF/ID register.
- Obeys the hazard-detection stall and the EX-stage branch redirect, which discards stale in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; also the cap on outstanding plus buffered fetches. Power of two, minimum 2.
- NOP_INST, 32'h0000_0013, instruction driven on if_inst when if_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  1  from hazard detection; 1 = decode is not consuming this cycle.
- redirect_valid  in  1  branch/jump taken, from EX.
- redirect_pc  in  32  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address, word-aligned.
- imem_resp_valid  in  1  response valid; always accepted, never backpressured.
- imem_resp_inst  in  32  returned instruction.
- if_valid  out  1  if_inst/if_pc hold a real instruction.
- if_pc  out  32  PC of if_inst.
- if_inst  out  32  instruction to IF/ID.
- if_opcode  out  7  if_inst[6:0].
- if_rd  out  5  if_inst[11:7].
- if_rs1  out  5  if_inst[19:15].
- if_rs2  out  5  if_inst[24:20].

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - imem_req_valid=0; if_valid=0; if_inst=NOP_INST; if_pc=RESET_PC.
- Request issue:
  - imem_req_valid=1 when outstanding+fifo_count < FIFO_DEPTH and no redirect this cycle.
  - imem_req_addr=pc.
  - Handshake is a cycle with valid&ready; on that cycle pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0) and outstanding+1.
  - Once asserted, valid and addr hold until ready.
- Responses:
  - In request order, at least 1 cycle after acceptance; outstanding-1 on each.
  - If drop_cnt>0: discard and drop_cnt-1.
  - Otherwise push {pc_of_request, inst}. The PC of each accepted request is tracked in a FIFO_DEPTH-entry PC queue.
  - The credit rule guarantees a push never overflows; an overflow is an assertion failure.
- Output:
  - Head of FIFO drives if_inst/if_pc; if_valid = !empty. Decoded fields are combinational slices of if_inst.
  - Pop when if_valid & !stall.
  - When empty: if_inst=NOP_INST, if_pc=last presented PC.
  - No response-to-output bypass: a response arriving in cycle N is visible in N+1.
  - Minimum fetch-to-output latency is 2 cycles after the request handshake.
- Redirect (priority over everything):
  - Same cycle: imem_req_valid forced 0.
  - Next edge:
    - pc<=redirect_pc with bits [1:0] cleared.
    - FIFO and PC queue flushed.
    - drop_cnt <= outstanding after counting any response arriving that same cycle; that response is itself dropped.
  - Applies regardless of stall.
  - First request from the new PC is issued the cycle after the redirect.
- Stall: holds the FIFO head and outputs stable. Fetch continues until credits run out, then imem_req_valid drops.
- Simultaneous pop and push: occupancy unchanged, head advances.
- Redirect while imem_req_valid=1 and ready=0: the pending request is withdrawn. This is the only permitted case of valid falling without a handshake.
- Reset mid-operation: all state is cleared immediately. Responses to pre-reset requests are the memory's responsibility; the memory is reset by the same rst.

Test Plan:
- Reset release, ready=1, 1-cycle memory, stall=0 -> addresses 0x0,0x4,0x8 issued on consecutive cycles; if_valid rises 2 cycles after the first handshake; if_pc/if_inst stream in order, one per cycle.
- stall=1 for 5 cycles with instruction at 0x8 at head -> if_pc holds 0x8; exactly FIFO_DEPTH requests outstanding+buffered, then imem_req_valid=0; release -> 0xC follows 0x8, nothing lost or duplicated.
- redirect_valid=1, redirect_pc=0x100 with 2 fetches outstanding -> both responses discarded; next if_valid instruction has if_pc=0x100; no 0x10/0x14 ever presented.
- imem_req_ready=0 for 4 cycles -> imem_req_valid and addr 0x4 held stable; redirect to 0x203 during wait -> request withdrawn, next request addr 0x200.
- Redirect in the same cycle as a response arrives and stall=1 -> response dropped, FIFO empty next cycle, if_valid=0, if_inst=0x0000_0013.
- Fetch with inst 0x00B5_0533 (add x10,x10,x11) -> if_opcode=0x33, if_rd=10, if_rs1=10, if_rs2=11; PC wrap at 0xFFFF_FFFC -> next request addr 0x0.

Source files
------------

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// Requests use valid/ready; responses are always accepted, so they carry no ready.
interface if_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_inst;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_inst
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_inst
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, issues in-order imem requests under a credit limit,
// buffers responses and hands one instruction per cycle (with PC and fields) to IF/ID.
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    if_fetch_if.master        imem,
    output logic              if_valid,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_inst,
    output logic [6:0]        if_opcode,
    output logic [4:0]        if_rd,
    output logic [4:0]        if_rs1,
    output logic [4:0]        if_rs2
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    fetch_entry_t  fifo_q [FIFO_DEPTH];
    logic [31:0]   pcq_q  [FIFO_DEPTH];
    logic [AW-1:0] fifo_rd, fifo_wr;
    logic [AW-1:0] pcq_rd, pcq_wr;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [31:0]   pc;
    logic [31:0]   last_pc;
    logic          run;

    logic          req_fire;
    logic          resp_keep;
    logic          resp_drop;
    logic          fifo_pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW:0]   in_use;

    // Every accepted request reserves a buffer slot, so a response can never overflow.
    assign in_use     = {1'b0, outstanding} + {1'b0, fifo_cnt};
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == DEPTH_W[CW-1:0]);
    assign fifo_pop   = !fifo_empty && !stall;

    assign imem.imem_req_valid = run && !redirect_valid && (in_use < DEPTH_W);
    assign imem.imem_req_addr  = pc;
    assign req_fire  = imem.imem_req_valid && imem.imem_req_ready;
    assign resp_drop = imem.imem_resp_valid && (drop_cnt != '0);
    assign resp_keep = imem.imem_resp_valid && (drop_cnt == '0);

    assign if_valid  = !fifo_empty;
    assign if_inst   = fifo_empty ? NOP_INST : fifo_q[fifo_rd].inst;
    assign if_pc     = fifo_empty ? last_pc  : fifo_q[fifo_rd].pc;
    assign if_opcode = if_inst[6:0];
    assign if_rd     = if_inst[11:7];
    assign if_rs1    = if_inst[19:15];
    assign if_rs2    = if_inst[24:20];

    // Storage arrays carry no reset; occupancy is tracked by the pointers below.
    always_ff @(posedge clk) begin
        if (resp_keep && !redirect_valid)
            fifo_q[fifo_wr] <= '{pc: pcq_q[pcq_rd], inst: imem.imem_resp_inst};
        if (req_fire)
            pcq_q[pcq_wr] <= pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            last_pc     <= RESET_PC;
            run         <= 1'b0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            fifo_cnt    <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            run <= 1'b1;
            if (!fifo_empty)
                last_pc <= fifo_q[fifo_rd].pc;

            if (redirect_valid) begin
                // Everything still in flight becomes stale, including a response landing now.
                pc          <= redirect_pc & ~32'h3;
                fifo_rd     <= '0;
                fifo_wr     <= '0;
                fifo_cnt    <= '0;
                pcq_rd      <= '0;
                pcq_wr      <= '0;
                outstanding <= outstanding - CW'(imem.imem_resp_valid);
                drop_cnt    <= outstanding - CW'(imem.imem_resp_valid);
            end else begin
                if (req_fire) begin
                    pc     <= pc + 32'd4;
                    pcq_wr <= pcq_wr + AW'(1);
                end
                outstanding <= outstanding + CW'(req_fire) - CW'(imem.imem_resp_valid);
                if (resp_drop)
                    drop_cnt <= drop_cnt - CW'(1);
                if (resp_keep) begin
                    fifo_wr <= fifo_wr + AW'(1);
                    pcq_rd  <= pcq_rd + AW'(1);
                end
                if (fifo_pop)
                    fifo_rd <= fifo_rd + AW'(1);
                fifo_cnt <= fifo_cnt + CW'(resp_keep) - CW'(fifo_pop);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(resp_keep && !redirect_valid && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: imem model with programmable latency, output scoreboard,
// decode vector table and directed stall / redirect / backpressure / wrap sequences.
`timescale 1ns/1ps
module tb_if_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_pc, if_inst;
    logic [6:0]  if_opcode;
    logic [4:0]  if_rd, if_rs1, if_rs2;

    if_fetch_if mif();

    if_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem(mif),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .if_opcode(if_opcode), .if_rd(if_rd), .if_rs1(if_rs1), .if_rs2(if_rs2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
    } dec_vec_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    dec_vec_t    vec [4];
    exp_t        exp_q [$];
    logic [31:0] pend_addr [$];
    int          pend_due [$];
    logic [31:0] hs_log [$];
    int          cyc = 0;
    int          mem_lat = 1;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_inst(input logic [31:0] a);
        if (a >= 32'h400 && a < 32'h410) return vec[(a - 32'h400) >> 2].inst;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        #1 check("redir_kills_req", 32'(mif.imem_req_valid), 32'd0);
        @(posedge clk); #2;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!if_valid && n < 60) begin step(); n++; end
        check(name, 32'(if_valid), 32'd1);
    endtask

    task automatic wait_pc(input logic [31:0] pc, input string name);
        int n = 0;
        while (!(if_valid && if_pc == pc) && n < 60) begin step(); n++; end
        check(name, 32'(if_valid && if_pc == pc), 32'd1);
    endtask

    // imem model: responds in order once each request's due cycle is reached
    initial begin
        mif.imem_resp_valid = 1'b0;
        mif.imem_resp_inst = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                pend_addr.delete();
                pend_due.delete();
                mif.imem_resp_valid = 1'b0;
            end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                mif.imem_resp_valid = 1'b1;
                mif.imem_resp_inst = mem_inst(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                mif.imem_resp_valid = 1'b0;
            end
        end
    end

    // Monitor/scoreboard: accepted requests are expected in order unless a redirect flushes them
    initial begin
        logic        prev_wait;
        logic [31:0] prev_addr;
        exp_t        e;
        prev_wait = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                prev_wait = 1'b0;
            end else begin
                if (prev_wait && !redirect_valid) begin
                    check("req_hold_valid", 32'(mif.imem_req_valid), 32'd1);
                    check("req_hold_addr", mif.imem_req_addr, prev_addr);
                end
                if (!if_valid) begin
                    check("nop_when_empty", if_inst, NOP);
                end else if (!stall) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got pc %h want no output", if_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_pc", if_pc, e.pc);
                        check("out_inst", if_inst, e.inst);
                    end
                end
                if (mif.imem_req_valid && mif.imem_req_ready) begin
                    hs_log.push_back(mif.imem_req_addr);
                    pend_addr.push_back(mif.imem_req_addr);
                    pend_due.push_back(cyc + mem_lat);
                    exp_q.push_back('{pc: mif.imem_req_addr, inst: mem_inst(mif.imem_req_addr)});
                end
                prev_wait = mif.imem_req_valid && !mif.imem_req_ready;
                prev_addr = mif.imem_req_addr;
                if (redirect_valid) exp_q.delete();
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] saved_pc;
        vec[0] = '{inst: 32'h00B5_0533, op: 7'h33, rd: 5'd10, rs1: 5'd10, rs2: 5'd11};
        vec[1] = '{inst: 32'hFFF0_0093, op: 7'h13, rd: 5'd1,  rs1: 5'd0,  rs2: 5'd31};
        vec[2] = '{inst: 32'h00C5_8663, op: 7'h63, rd: 5'd12, rs1: 5'd11, rs2: 5'd12};
        vec[3] = '{inst: 32'h0002_A283, op: 7'h03, rd: 5'd5,  rs1: 5'd5,  rs2: 5'd0};
        mif.imem_req_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_req_valid", 32'(mif.imem_req_valid), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_inst", if_inst, NOP);
        check("rst_if_pc", if_pc, 32'h0);

        // Start-up stream and first-output latency
        rst = 1'b1;
        for (int n = 0; n < 20 && hs_log.size() == 0; n++) step();
        check("first_addr", hs_log.size() > 0 ? hs_log[0] : 32'hDEAD_BEEF, 32'h0);
        check("if_valid_h1", 32'(if_valid), 32'd0);
        step();
        check("if_valid_h2", 32'(if_valid), 32'd1);
        check("if_pc_h2", if_pc, 32'h0);

        // Stall with 0x8 at the head
        wait_pc(32'h8, "reach_pc8");
        check("t1_hs_count", 32'(hs_log.size() >= 3), 32'd1);
        check("t1_addr1", hs_log.size() >= 3 ? hs_log[1] : 32'hDEAD_BEEF, 32'h4);
        check("t1_addr2", hs_log.size() >= 3 ? hs_log[2] : 32'hDEAD_BEEF, 32'h8);
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("stall_pc", if_pc, 32'h8);
            check("stall_valid", 32'(if_valid), 32'd1);
            step();
        end
        check("stall_no_req", 32'(mif.imem_req_valid), 32'd0);
        check("stall_credits", 32'(exp_q.size()), 32'd2);
        check("stall_last_req", hs_log[hs_log.size() - 1], 32'hC);
        stall = 1'b0;
        step();
        check("after_stall_pc", if_pc, 32'hC);

        // Redirect with two fetches in flight
        mem_lat = 4;
        for (int n = 0; n < 30 && pend_addr.size() != 2; n++) step();
        check("two_in_flight", 32'(pend_addr.size()), 32'd2);
        do_redirect(32'h100);
        mem_lat = 1;
        wait_valid("redir_valid");
        check("redir_first_pc", if_pc, 32'h100);

        // Reset mid-operation, then request held under backpressure and withdrawn
        rst = 1'b0;
        #1;
        check("mid_rst_req", 32'(mif.imem_req_valid), 32'd0);
        check("mid_rst_valid", 32'(if_valid), 32'd0);
        check("mid_rst_pc", if_pc, 32'h0);
        check("mid_rst_inst", if_inst, NOP);
        step();
        step();
        hs_log.delete();
        rst = 1'b1;
        for (int n = 0; n < 20 && hs_log.size() == 0; n++) step();
        mif.imem_req_ready = 1'b0;
        check("bp_first_addr", hs_log.size() > 0 ? hs_log[0] : 32'hDEAD_BEEF, 32'h0);
        for (int k = 0; k < 4; k++) begin
            check("bp_valid", 32'(mif.imem_req_valid), 32'd1);
            check("bp_addr", mif.imem_req_addr, 32'h4);
            step();
        end
        do_redirect(32'h203);
        mif.imem_req_ready = 1'b1;
        hs_log.delete();
        for (int n = 0; n < 20 && hs_log.size() == 0; n++) step();
        check("withdraw_addr", hs_log.size() > 0 ? hs_log[0] : 32'hDEAD_BEEF, 32'h200);

        // Redirect in the same cycle as a response, while stalled
        stall = 1'b1;
        for (int n = 0; n < 20 && !mif.imem_resp_valid; n++) step();
        check("resp_present", 32'(mif.imem_resp_valid), 32'd1);
        saved_pc = if_pc;
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        check("rr_if_valid", 32'(if_valid), 32'd0);
        check("rr_if_inst", if_inst, NOP);
        check("rr_pc_hold", if_pc, saved_pc);
        stall = 1'b0;
        wait_valid("rr_valid");
        check("rr_first_pc", if_pc, 32'h300);

        // Decode-field vectors at 0x400
        do_redirect(32'h400);
        for (int i = 0; i < 4; i++) begin
            wait_pc(32'h400 + 32'(i) * 4, "vec_pc");
            check("vec_opcode", 32'(if_opcode), 32'(vec[i].op));
            check("vec_rd", 32'(if_rd), 32'(vec[i].rd));
            check("vec_rs1", 32'(if_rs1), 32'(vec[i].rs1));
            check("vec_rs2", 32'(if_rs2), 32'(vec[i].rs2));
        end

        // PC wrap
        do_redirect(32'hFFFF_FFF8);
        hs_log.delete();
        for (int n = 0; n < 30 && hs_log.size() < 3; n++) step();
        check("wrap_hs_count", 32'(hs_log.size() >= 3), 32'd1);
        check("wrap_addr0", hs_log.size() >= 3 ? hs_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        check("wrap_addr1", hs_log.size() >= 3 ? hs_log[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("wrap_addr2", hs_log.size() >= 3 ? hs_log[2] : 32'hDEAD_BEEF, 32'h0);
        wait_pc(32'h0, "wrap_out");
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
